// File: rtl/onchip_mem_init_pkg.sv
// Shared types and constants for the on-chip RAM fill/verify initiator.
package onchip_mem_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_DRAIN = 3'd3,
        ST_FINISH   = 3'd4
    } state_e;

    localparam logic MODE_FILL   = 1'b0;
    localparam logic MODE_VERIFY = 1'b1;

    localparam int unsigned DEFAULT_DEPTH = 32'd8216;
    localparam int unsigned DEFAULT_AW    = 32'd14;

    localparam logic [15:0] ERR_SAT = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] count);
        if (count == ERR_SAT) begin
            sat_inc16 = ERR_SAT;
        end else begin
            sat_inc16 = count + 16'd1;
        end
    endfunction

endpackage

// File: rtl/onchip_mem_addr_gen.sv
// Wrapping word-address / index counter shared by the fill and read-issue phases.
module onchip_mem_addr_gen
    import onchip_mem_init_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          inc,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 32'd1);

    logic [AW-1:0] addr_r;
    logic [AW:0]   idx_r;
    logic [AW:0]   len_r;

    // Address/index registers; wrap is a compare against the last word, never a modulo.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r <= {AW{1'b0}};
            idx_r  <= {(AW+1){1'b0}};
            len_r  <= {(AW+1){1'b0}};
        end else if (load) begin
            addr_r <= base;
            idx_r  <= {(AW+1){1'b0}};
            len_r  <= len;
        end else if (inc) begin
            addr_r <= (addr_r == ADDR_MAX) ? {AW{1'b0}} : addr_r + AW'(1);
            idx_r  <= idx_r + (AW+1)'(1);
        end else begin
            addr_r <= addr_r;
            idx_r  <= idx_r;
            len_r  <= len_r;
        end
    end

    assign addr = addr_r;
    assign last = (idx_r == len_r - (AW+1)'(1));

endmodule

// File: rtl/onchip_mem_initiator.sv
// Avalon-MM master that fills the on-chip RAM with seed+i, or reads it back and
// counts mismatches, at one word per clock.
module onchip_mem_initiator
    import onchip_mem_init_pkg::*;
#(
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned AW           = DEFAULT_AW,
    parameter int unsigned READ_LATENCY = 32'd1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
    input  logic [31:0]   seed,
    output logic          busy,
    output logic          done,
    output logic          cmd_err,
    output logic [15:0]   err_count,
    output logic [AW-1:0] first_err_addr,
    output logic [AW-1:0] address,
    output logic [3:0]    byteenable,
    output logic          chipselect,
    output logic          write,
    output logic [31:0]   writedata,
    output logic          clken,
    input  logic [31:0]   readdata
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    // Any other latency would compare misaligned data, so checking is disabled instead.
    localparam logic LAT_SUPPORTED = (READ_LATENCY == 32'd1);

    state_e state_r, state_s;

    logic          accept_s, load_s, inc_s, cs_s, we_s, busy_s, done_s;
    logic          bad_cmd_s, last_s;
    logic [AW-1:0] gen_addr_s;
    logic [31:0]   pat_r, pat_next_s;

    logic          chipselect_r, write_r, busy_r, done_r, cmd_err_r, clken_r;
    logic [3:0]    byteenable_r;
    logic [31:0]   writedata_r;

    logic          cmp_valid_r;
    logic [31:0]   exp_data_r;
    logic [AW-1:0] exp_addr_r;
    logic [15:0]   err_count_r;
    logic [AW-1:0] first_err_addr_r;

    assign bad_cmd_s = ({1'b0, base_addr} >= DEPTH_W) || (length > DEPTH_W);

    onchip_mem_addr_gen #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_addr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_s),
        .inc     (inc_s),
        .base    (base_addr),
        .len     (length),
        .addr    (gen_addr_s),
        .last    (last_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state plus the bus/status values to be registered for the following cycle.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        load_s   = 1'b0;
        inc_s    = 1'b0;
        cs_s     = 1'b0;
        we_s     = 1'b0;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    if (bad_cmd_s) begin
                        state_s = ST_FINISH;
                        done_s  = 1'b1;
                    end else if (length == (AW+1)'(0)) begin
                        state_s = ST_FINISH;
                        done_s  = 1'b1;
                    end else begin
                        load_s = 1'b1;
                        cs_s   = 1'b1;
                        busy_s = 1'b1;
                        if (mode == MODE_VERIFY) begin
                            state_s = ST_RD_ISSUE;
                        end else begin
                            state_s = ST_FILL;
                            we_s    = 1'b1;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (last_s) begin
                    state_s = ST_FINISH;
                    done_s  = 1'b1;
                end else begin
                    inc_s  = 1'b1;
                    cs_s   = 1'b1;
                    we_s   = 1'b1;
                    busy_s = 1'b1;
                end
            end
            ST_RD_ISSUE: begin
                if (last_s) begin
                    state_s = ST_RD_DRAIN;
                    busy_s  = 1'b1;
                end else begin
                    inc_s  = 1'b1;
                    cs_s   = 1'b1;
                    busy_s = 1'b1;
                end
            end
            ST_RD_DRAIN: begin
                state_s = ST_FINISH;
                done_s  = 1'b1;
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Pattern adder: seed on load, +1 per advanced index.
    always_comb begin
        if (load_s) begin
            pat_next_s = seed;
        end else if (inc_s) begin
            pat_next_s = pat_r + 32'd1;
        end else begin
            pat_next_s = pat_r;
        end
    end

    // Registered bus outputs, handshake flags and the current-index pattern.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chipselect_r <= 1'b0;
            write_r      <= 1'b0;
            byteenable_r <= 4'h0;
            writedata_r  <= 32'h0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            clken_r      <= 1'b0;
            pat_r        <= 32'h0;
        end else begin
            chipselect_r <= cs_s;
            write_r      <= we_s;
            byteenable_r <= cs_s ? 4'hF : 4'h0;
            writedata_r  <= we_s ? pat_next_s : 32'h0;
            busy_r       <= busy_s;
            done_r       <= done_s;
            clken_r      <= 1'b1;
            pat_r        <= pat_next_s;
        end
    end

    // One-deep compare pipe: captures what the read issued this cycle should return.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp_valid_r <= 1'b0;
            exp_data_r  <= 32'h0;
            exp_addr_r  <= {AW{1'b0}};
        end else begin
            cmp_valid_r <= chipselect_r && !write_r && LAT_SUPPORTED;
            exp_data_r  <= pat_r;
            exp_addr_r  <= gen_addr_s;
        end
    end

    // Result registers: cleared by an accepted start, then updated by each compare.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count_r      <= 16'h0;
            first_err_addr_r <= {AW{1'b0}};
            cmd_err_r        <= 1'b0;
        end else if (accept_s) begin
            err_count_r      <= 16'h0;
            first_err_addr_r <= {AW{1'b0}};
            cmd_err_r        <= bad_cmd_s;
        end else if (cmp_valid_r && (readdata != exp_data_r)) begin
            if (err_count_r == 16'h0) begin
                first_err_addr_r <= exp_addr_r;
            end else begin
                first_err_addr_r <= first_err_addr_r;
            end
            err_count_r <= sat_inc16(err_count_r);
        end else begin
            err_count_r      <= err_count_r;
            first_err_addr_r <= first_err_addr_r;
            cmd_err_r        <= cmd_err_r;
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign cmd_err        = cmd_err_r;
    assign err_count      = err_count_r;
    assign first_err_addr = first_err_addr_r;
    assign address        = gen_addr_s;
    assign byteenable     = byteenable_r;
    assign chipselect     = chipselect_r;
    assign write          = write_r;
    assign writedata      = writedata_r;
    assign clken          = clken_r;

endmodule

// File: tb/tb_onchip_mem_initiator.sv
// Directed self-checking bench for onchip_mem_initiator with a 1-cycle-latency RAM model.
module tb_onchip_mem_initiator;

    localparam int DEPTH = 8216;
    localparam int AW    = 14;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic [31:0]   seed = 32'h0;
    logic          busy, done, cmd_err, chipselect, write, clken;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr, address;
    logic [3:0]    byteenable;
    logic [31:0]   writedata;
    logic [31:0]   rd_q = 32'h0;
    logic [31:0]   mem [0:DEPTH-1];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    onchip_mem_initiator dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .mode           (mode),
        .base_addr      (base_addr),
        .length         (length),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .cmd_err        (cmd_err),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .address        (address),
        .byteenable     (byteenable),
        .chipselect     (chipselect),
        .write          (write),
        .writedata      (writedata),
        .clken          (clken),
        .readdata       (rd_q)
    );

    // RAM model: synchronous write, registered read (latency 1).
    always @(posedge clk) begin
        if (chipselect && write) mem[address] <= writedata;
        if (chipselect) rd_q <= mem[address];
    end

    task automatic start_cmd(input logic m, input logic [AW-1:0] b, input logic [AW:0] l,
                             input logic [31:0] s);
        @(negedge clk);
        mode = m; base_addr = b; length = l; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int first, input int limit, output int at);
        at = -1;
        for (int c = first; c <= limit; c++) begin
            if (c > first) @(negedge clk);
            if (done === 1'b1) begin
                at = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, chipselect, write, cmd_err, clken} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {busy, done, chipselect, write, cmd_err, clken});
        end
        checks++;
        if ({address, byteenable, writedata} !== '0) begin
            failures++;
            $display("FAIL reset_bus got=%h/%h/%h exp=0", address, byteenable, writedata);
        end
        checks++;
        if ({err_count, first_err_addr} !== '0) begin
            failures++;
            $display("FAIL reset_err got=%h/%h exp=0", err_count, first_err_addr);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({clken, busy} !== 2'b10) begin
            failures++;
            $display("FAIL reset_clken got=%b exp=10", {clken, busy});
        end
    endtask

    task automatic test_fill;
        start_cmd(1'b0, 14'd0, 15'd4, 32'h0000_1000);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({chipselect, write, busy, done, byteenable} !== 8'b1110_1111) begin
                failures++;
                $display("FAIL fill_ctrl c%0d got=%b exp=11101111", c, {chipselect, write, busy, done, byteenable});
            end
            checks++;
            if (address !== 14'(c - 1)) begin
                failures++;
                $display("FAIL fill_addr c%0d got=%0d exp=%0d", c, address, c - 1);
            end
            checks++;
            if (writedata !== 32'h0000_1000 + 32'(c - 1)) begin
                failures++;
                $display("FAIL fill_data c%0d got=%h exp=%h", c, writedata, 32'h1000 + 32'(c - 1));
            end
            @(negedge clk);
        end
        checks++;
        if ({done, busy, chipselect, cmd_err} !== 4'b1000) begin
            failures++;
            $display("FAIL fill_done got=%b exp=1000", {done, busy, chipselect, cmd_err});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[i] !== 32'h0000_1000 + 32'(i)) begin
                failures++;
                $display("FAIL fill_mem a%0d got=%h exp=%h", i, mem[i], 32'h1000 + 32'(i));
            end
        end
    endtask

    task automatic test_verify_errors;
        int at;
        start_cmd(1'b0, 14'd0, 15'd16, 32'hA5A5_0000);
        wait_done(1, 40, at);
        checks++;
        if (at != 17) begin failures++; $display("FAIL verr_fill_done got=%0d exp=17", at); end
        start_cmd(1'b0, 14'd5, 15'd1, 32'h0BAD_0005);
        wait_done(1, 10, at);
        checks++;
        if (at != 2) begin failures++; $display("FAIL verr_corrupt5 got=%0d exp=2", at); end
        start_cmd(1'b0, 14'd9, 15'd1, 32'h0BAD_0009);
        wait_done(1, 10, at);
        start_cmd(1'b1, 14'd0, 15'd16, 32'hA5A5_0000);
        checks++;
        if ({chipselect, write, address} !== {2'b10, 14'd0}) begin
            failures++;
            $display("FAIL verr_rd1 got=%b/%0d exp=10/0", {chipselect, write}, address);
        end
        wait_done(1, 40, at);
        checks++;
        if (at != 18) begin failures++; $display("FAIL verr_done got=%0d exp=18", at); end
        checks++;
        if (err_count !== 16'd2) begin failures++; $display("FAIL verr_count got=%0d exp=2", err_count); end
        checks++;
        if (first_err_addr !== 14'd5) begin failures++; $display("FAIL verr_first got=%0d exp=5", first_err_addr); end
        @(negedge clk);
        checks++;
        if ({err_count, first_err_addr, busy} !== {16'd2, 14'd5, 1'b0}) begin
            failures++;
            $display("FAIL verr_hold got=%0d/%0d/%b exp=2/5/0", err_count, first_err_addr, busy);
        end
    endtask

    task automatic test_reject;
        start_cmd(1'b0, 14'd8216, 15'd4, 32'h0);
        checks++;
        if ({done, cmd_err, chipselect, busy} !== 4'b1100) begin
            failures++;
            $display("FAIL rej_base got=%b exp=1100", {done, cmd_err, chipselect, busy});
        end
        checks++;
        if ({err_count, first_err_addr} !== '0) begin
            failures++;
            $display("FAIL rej_clear got=%0d/%0d exp=0/0", err_count, first_err_addr);
        end
        @(negedge clk);
        checks++;
        if ({done, cmd_err, chipselect} !== 3'b010) begin
            failures++;
            $display("FAIL rej_hold got=%b exp=010", {done, cmd_err, chipselect});
        end
        start_cmd(1'b1, 14'd0, 15'd8217, 32'h0);
        checks++;
        if ({done, cmd_err, chipselect, busy} !== 4'b1100) begin
            failures++;
            $display("FAIL rej_len got=%b exp=1100", {done, cmd_err, chipselect, busy});
        end
        @(negedge clk);
        checks++;
        if (chipselect !== 1'b0) begin failures++; $display("FAIL rej_bus got=%b exp=0", chipselect); end
    endtask

    task automatic test_wrap;
        int at;
        logic [AW-1:0] wa [4];
        logic [31:0]   wd [4];
        wa = '{14'd8214, 14'd8215, 14'd0, 14'd1};
        wd = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        start_cmd(1'b0, 14'd8214, 15'd4, 32'hFFFF_FFFE);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({chipselect, write, address, writedata} !== {2'b11, wa[c-1], wd[c-1]}) begin
                failures++;
                $display("FAIL wrap_fill c%0d got=%b/%0d/%h exp=11/%0d/%h", c, {chipselect, write},
                         address, writedata, wa[c-1], wd[c-1]);
            end
            @(negedge clk);
        end
        checks++;
        if ({done, busy} !== 2'b10) begin failures++; $display("FAIL wrap_fill_done got=%b exp=10", {done, busy}); end
        start_cmd(1'b1, 14'd8214, 15'd4, 32'hFFFF_FFFE);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({chipselect, write, address} !== {2'b10, wa[c-1]}) begin
                failures++;
                $display("FAIL wrap_rd c%0d got=%b/%0d exp=10/%0d", c, {chipselect, write}, address, wa[c-1]);
            end
            @(negedge clk);
        end
        checks++;
        if ({chipselect, busy, done} !== 3'b010) begin
            failures++;
            $display("FAIL wrap_drain got=%b exp=010", {chipselect, busy, done});
        end
        wait_done(5, 10, at);
        checks++;
        if (at != 6) begin failures++; $display("FAIL wrap_vdone got=%0d exp=6", at); end
        checks++;
        if ({err_count, first_err_addr, cmd_err} !== '0) begin
            failures++;
            $display("FAIL wrap_verr got=%0d/%0d/%b exp=0/0/0", err_count, first_err_addr, cmd_err);
        end
    endtask

    task automatic test_reset_mid;
        int at;
        start_cmd(1'b0, 14'd100, 15'd10, 32'h55);
        repeat (3) @(negedge clk);
        checks++;
        if (address !== 14'd103) begin failures++; $display("FAIL rmid_addr got=%0d exp=103", address); end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({chipselect, busy, done, write} !== 4'b0) begin
            failures++;
            $display("FAIL rmid_async got=%b exp=0000", {chipselect, busy, done, write});
        end
        @(negedge clk);
        reset_n = 1'b1;
        start_cmd(1'b0, 14'd200, 15'd2, 32'h7);
        checks++;
        if ({chipselect, write, address, writedata} !== {2'b11, 14'd200, 32'h7}) begin
            failures++;
            $display("FAIL rmid_restart got=%b/%0d/%h exp=11/200/7", {chipselect, write}, address, writedata);
        end
        wait_done(1, 10, at);
        checks++;
        if (at != 3) begin failures++; $display("FAIL rmid_done got=%0d exp=3", at); end
        checks++;
        if ({mem[200], mem[201], mem[102]} !== {32'h7, 32'h8, 32'h57}) begin
            failures++;
            $display("FAIL rmid_mem got=%h/%h/%h exp=7/8/57", mem[200], mem[201], mem[102]);
        end
    endtask

    task automatic test_busy_start_len0;
        int at;
        start_cmd(1'b0, 14'd300, 15'd6, 32'h10);
        @(negedge clk);
        mode = 1'b1; base_addr = 14'd0; length = 15'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({write, address} !== {1'b1, 14'd302}) begin
            failures++;
            $display("FAIL busy_ignore got=%b/%0d exp=1/302", write, address);
        end
        wait_done(3, 20, at);
        checks++;
        if (at != 7) begin failures++; $display("FAIL busy_done got=%0d exp=7", at); end
        mode = 1'b0; base_addr = 14'd400; length = 15'd3; seed = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({chipselect, busy} !== 2'b00) begin
            failures++;
            $display("FAIL finish_ignore got=%b exp=00", {chipselect, busy});
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mem[300 + i] !== 32'h10 + 32'(i)) begin
                failures++;
                $display("FAIL busy_mem a%0d got=%h exp=%h", 300 + i, mem[300 + i], 32'h10 + 32'(i));
            end
        end
        start_cmd(1'b0, 14'd8216, 15'd1, 32'h0);
        checks++;
        if ({done, cmd_err} !== 2'b11) begin failures++; $display("FAIL len0_pre got=%b exp=11", {done, cmd_err}); end
        start_cmd(1'b0, 14'd50, 15'd0, 32'h0);
        checks++;
        if ({done, cmd_err, chipselect, busy} !== 4'b1000) begin
            failures++;
            $display("FAIL len0 got=%b exp=1000", {done, cmd_err, chipselect, busy});
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_verify_errors();
        test_reject();
        test_wrap();
        test_reset_mid();
        test_busy_start_len0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/onchip_mem_initiator.md
# onchip_mem_initiator

Avalon-MM master that fills and verifies the 32-bit single-port on-chip RAM. Given a base word address, a word count and a seed, it writes the pattern seed+i, or reads back and checks it, at one access per clock. It sits beside the Nios II data master as a bring-up and self-test engine. It drives the RAM slave port directly, or through the interconnect with zero wait states.

## Interface
Parameters:
- DEPTH, 8216, number of 32-bit words in the target RAM
- AW, 14, address width in words
- READ_LATENCY, 1, cycles from read-address cycle to valid readdata; fixed at 1, other values unsupported

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- mode  in  1  0 = FILL, 1 = VERIFY
- base_addr  in  AW  first word address
- length  in  AW+1  word count, 0..DEPTH
- seed  in  32  pattern seed
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at command completion
- cmd_err  out  1  command rejected; valid with done
- err_count  out  16  VERIFY mismatch count, saturates at 0xFFFF
- first_err_addr  out  AW  address of the first mismatch; 0 if none
- address  out  AW  to RAM
- byteenable  out  4  always 4'hF while chipselect is high, otherwise 0
- chipselect  out  1  access valid this cycle
- write  out  1  write qualifier
- writedata  out  32  write data
- clken  out  1  RAM clock enable; constant 1 after reset
- readdata  in  32  from RAM

## Operation
- States: IDLE, FILL, RD_ISSUE, RD_DRAIN, FINISH.
- IDLE + start:
  - Latch base_addr, length, seed and mode.
  - Clear err_count and first_err_addr.
  - If base_addr >= DEPTH or length > DEPTH: go to FINISH with cmd_err=1.
  - Else if length = 0: go to FINISH with cmd_err=0.
  - Else: go to FILL (mode 0) or RD_ISSUE (mode 1).
- Index i runs 0..length-1.
- Access address = base + i. When this reaches DEPTH it wraps to 0; compute it as an incrementing counter with compare-to-DEPTH, not a modulo.
- Pattern(i) = seed + i, modulo 2^32.
- FILL:
  - Each cycle: chipselect=1, write=1, address=addr(i), writedata=pattern(i).
  - After i = length-1, go to FINISH.
- RD_ISSUE:
  - Each cycle: chipselect=1, write=0, address=addr(i).
  - Push the expected pattern and address into a 1-deep compare pipe.
  - After i = length-1, go to RD_DRAIN.
- Compare: one cycle after each read issue, compare readdata with the piped expected value.
  - On mismatch: err_count increments, saturating at 0xFFFF.
  - On the first mismatch only: first_err_addr takes the piped address.
- RD_DRAIN: one cycle, bus idle, performs the final compare, then goes to FINISH.
- FINISH:
  - done=1 and busy=0 for one cycle; cmd_err valid in this cycle.
  - Return to IDLE.
  - err_count, first_err_addr and cmd_err hold until the next accepted start.
- start while busy, or in FINISH, is ignored.
- Asynchronous reset (reset_n low), including mid-command:
  - State returns to IDLE.
  - All outputs go to 0, except clken which is 1 after release.
  - No partial results are retained.

## Timing
- start accepted at the edge ending cycle T. First bus access in cycle T+1.
- FILL of L words: writes in cycles T+1..T+L; done in cycle T+L+1.
- VERIFY of L words:
  - Reads in cycles T+1..T+L.
  - Data for the read in cycle k is compared in cycle k+1.
  - err outputs update at the end of cycle k+1.
  - done in cycle T+L+2.
- Rejected command or L=0: done in cycle T+1; no bus activity.
- Throughput: 1 word per clock; no bubbles at address wrap.
- All outputs are registered. chipselect, write, address and writedata change only on clk edges.

## Structure
- Package onchip_mem_init_pkg holds:
  - the state enum;
  - MODE_FILL / MODE_VERIFY constants;
  - default DEPTH and AW;
  - the ERR_SAT = 16'hFFFF constant.
- Sub-module onchip_mem_addr_gen is a wrapping address/index counter with load, increment, last-index flag and DEPTH wrap. It is shared by the FILL and RD_ISSUE phases.
- The top level holds the FSM, pattern adder, compare pipe and error registers.

## Test plan
- FILL base=0, L=4, seed=0x1000 -> writes 0x1000..0x1003 to addresses 0..3 in cycles T+1..T+4; done at T+5; busy high T+1..T+4.
- FILL then VERIFY, base=8214, L=4, seed=0xFFFFFFFE -> addresses 8214, 8215, 0, 1; data FFFFFFFE, FFFFFFFF, 0, 1; VERIFY gives err_count=0, first_err_addr=0.
- VERIFY with the RAM model corrupted at addresses 5 and 9 (base=0, L=16) -> err_count=2, first_err_addr=5; done at T+18.
- base=8216 or length=8217 -> done at T+1 with cmd_err=1; chipselect never asserted.
- Assert reset_n low at i=3 of a 10-word FILL -> chipselect, busy and done immediately 0; a subsequent start runs normally.
- Pulse start while busy, and length=0 -> the busy start is ignored; length=0 gives done at T+1 with cmd_err=0.
